timer_io: RTL and testbench
===========================

Name: timer_io

Overview:
- Memory-mapped interval timer on the processor bus, at address region ADDR[15:12] == 4'h4.
- Consumes the processor's ADDR/DOUT/W write path, like the LED and seg7 ports.
- Drives a read-data word into the top-level DIN mux, like SW_reg.
- Lets programs poll for fixed-period timeouts, such as 1 s at 50 MHz, instead of using software delay loops.

Parameters:
- PERIOD_RST, 32'd50000000: reset value of the period register, in clock cycles.

Ports:
- Clock  in  1  system clock (CLOCK_50 at top level).
- Resetn  in  1  synchronous active-low reset, sampled on the rising Clock edge.
- cs  in  1  chip select, driven by (ADDR[15:12] == 4'h4).
- A  in  3  register offset, ADDR[2:0].
- W  in  1  processor write strobe.
- D  in  16  write data, processor DOUT.
- Q  out  16  read data to the DIN mux.
- TO  out  1  timeout flag, for an LED or polling.

Behaviour:
- Interface: one clock, Clock. Reset Resetn is synchronous and active-low.
- Write occurs on the rising edge when cs & W. Writes to offsets 6 and 7 are ignored.
- Register map:
  - 0 STATUS: read {14'b0, RUN, TO}. Any write clears TO.
  - 1 CONTROL: write bit0 START, bit1 CONT, bit2 STOP. CONT is stored. Read {13'b0, 1'b0, CONT, RUN}.
  - 2 PERLO: period[15:0], read/write.
  - 3 PERHI: period[31:16], read/write.
  - 4 SNAPLO: any write copies the 32-bit count into snap. Read returns snap[15:0].
  - 5 SNAPHI: read snap[31:16].
  - 6, 7: read 16'h0000.
- Q is combinational from A and the register state; it does not depend on cs. The top-level mux gates it.
- Reset values: RUN=0, TO=0, CONT=0, count=0, snap=0, period=PERIOD_RST, Q reflects these values.
- Counter: 32-bit down-counter.
  - START write: count <= period and RUN <= 1 on that edge. START while running restarts the count from period.
  - While RUN is set and count > 1: count decrements by 1 each cycle.
  - While RUN is set and count <= 1 (terminal): on that edge TO <= 1.
    - If CONT=1: count <= period and RUN stays 1.
    - If CONT=0: count <= 0 and RUN <= 0.
  - Resulting timing: with period P >= 1, TO rises exactly P cycles after the START edge. In continuous mode it rises again every P cycles.
  - Period 0 behaves as 1: timeout every cycle.
- STOP write: RUN <= 0 and count is held. A later START reloads from period; there is no resume.
- Simultaneous events:
  - START and STOP in the same write: STOP wins and RUN <= 0.
  - STATUS write in the same cycle as terminal: the set wins and TO stays 1.
  - CONTROL write in the same cycle as terminal: the new CONT value decides reload versus stop on that edge.
  - SNAPLO write in the same cycle as a decrement captures the pre-edge count.
- Period written while running affects only the next reload or START, not the current count.
- TO is sticky: it stays 1 until a STATUS write or reset. Output TO equals the TO bit.
- Reset mid-count: on the edge with Resetn=0, all state returns to reset values regardless of cs/W in that cycle.
- Wrap-around: the counter never decrements below 0. A snapshot while stopped returns the held count.

Test Plan:
1. Reset, then read offsets 0–5 → Q = 0000, 0000, F080, 02FA, 0000, 0000. TO=0.
2. Write PERLO=5, PERHI=0, CONTROL=0x0001 (one-shot) → TO rises exactly 5 cycles after the START edge. STATUS reads 0x0001 (RUN=0, TO=1). Count=0.
3. Write CONTROL=0x0003 (continuous, P=5) → TO set at 5 cycles. Clear via STATUS write at cycle 7 → TO=0 at cycle 8, then set again at cycle 10. RUN stays 1.
4. P=100, START, write SNAPLO 10 cycles after the START edge → SNAPLO reads 90, SNAPHI reads 0. Then write CONTROL=0x0004 → RUN=0 and the count is frozen; a second snapshot also reads the frozen value.
5. Continuous P=3, STATUS write issued on the terminal cycle → TO remains 1. Separately, CONTROL=0x0005 (START+STOP) → RUN stays 0.
6. Running with P=1000, assert Resetn=0 for 1 cycle → next cycle RUN=0, TO=0, period reads 0x02FA_F080, and no TO occurs afterwards.

Source files
------------

// File: rtl/timer_io.sv
// Memory-mapped interval timer: programmable 32-bit down-counter with a sticky
// timeout flag, snapshot register and a combinational read-data word.
module timer_io #(
  parameter logic [31:0] PERIOD_RST = 32'd50000000
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        cs,
  input  logic [2:0]  A,
  input  logic        W,
  input  logic [15:0] D,
  output logic [15:0] Q,
  output logic        TO
);

  logic        run, to_flag, cont;
  logic [31:0] count, period, snap;

  logic        run_nx, to_nx, cont_nx;
  logic [31:0] count_nx, period_nx, snap_nx;

  logic wr, wr_status, wr_ctrl, wr_perlo, wr_perhi, wr_snap;
  logic terminal, ctrl_start, ctrl_stop;

  assign wr         = cs & W;
  assign wr_status  = wr && (A == 3'd0);
  assign wr_ctrl    = wr && (A == 3'd1);
  assign wr_perlo   = wr && (A == 3'd2);
  assign wr_perhi   = wr && (A == 3'd3);
  assign wr_snap    = wr && (A == 3'd4);
  assign ctrl_start = wr_ctrl & D[0];
  assign ctrl_stop  = wr_ctrl & D[2];

  // A loaded period of 0 is terminal immediately, so it behaves like 1.
  assign terminal = run && (count <= 32'd1);

  always_comb begin
    run_nx    = run;
    to_nx     = to_flag;
    cont_nx   = cont;
    count_nx  = count;
    period_nx = period;
    snap_nx   = snap;

    if (wr_ctrl)  cont_nx           = D[1];
    if (wr_perlo) period_nx[15:0]   = D;
    if (wr_perhi) period_nx[31:16]  = D;
    if (wr_snap)  snap_nx           = count;

    // Setting the flag beats a simultaneous clearing write.
    if (terminal)       to_nx = 1'b1;
    else if (wr_status) to_nx = 1'b0;

    // Reloads always use the pre-edge period; STOP overrides START.
    if (ctrl_stop) begin
      run_nx = 1'b0;
    end else if (ctrl_start) begin
      count_nx = period;
      run_nx   = 1'b1;
    end else if (terminal) begin
      if (cont_nx) begin
        count_nx = period;
      end else begin
        count_nx = 32'd0;
        run_nx   = 1'b0;
      end
    end else if (run) begin
      count_nx = count - 32'd1;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      run     <= 1'b0;
      to_flag <= 1'b0;
      cont    <= 1'b0;
      count   <= 32'd0;
      period  <= PERIOD_RST;
      snap    <= 32'd0;
    end else begin
      run     <= run_nx;
      to_flag <= to_nx;
      cont    <= cont_nx;
      count   <= count_nx;
      period  <= period_nx;
      snap    <= snap_nx;
    end
  end

  always_comb begin
    Q = 16'h0000;
    case (A)
      3'd0:    Q = {14'b0, run, to_flag};
      3'd1:    Q = {13'b0, 1'b0, cont, run};
      3'd2:    Q = period[15:0];
      3'd3:    Q = period[31:16];
      3'd4:    Q = snap[15:0];
      3'd5:    Q = snap[31:16];
      default: Q = 16'h0000;
    endcase
  end

  assign TO = to_flag;

endmodule

// File: tb/tb_timer_io.sv
// Bench for timer_io: directed bus writes, an event/time-based reference model
// checked every cycle, and literal expectations taken from the register map.
module tb_timer_io;

  localparam logic [31:0] PRST = 32'd50000000;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        cs = 1'b0;
  logic [2:0]  A = 3'd0;
  logic        W = 1'b0;
  logic [15:0] D = 16'h0000;
  logic [15:0] Q;
  logic        TO;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  logic [2:0] rot = 3'd0;

  timer_io #(.PERIOD_RST(PRST)) dut (
    .Clock(Clock), .Resetn(Resetn), .cs(cs), .A(A), .W(W), .D(D), .Q(Q), .TO(TO)
  );

  always #5 Clock = ~Clock;

  // Reference model: a running timer is described by the period it was loaded
  // with and the cycle of that load; the count is derived from elapsed time.
  longint      cyc = 0;
  longint      m_t0 = 0;
  logic [31:0] m_load = 32'd0;
  logic [31:0] m_held = 32'd0;
  logic [31:0] m_period = PRST;
  logic [31:0] m_snap = 32'd0;
  logic        m_run = 1'b0, m_to = 1'b0, m_cont = 1'b0;

  function automatic logic [31:0] m_count();
    if (m_run) return m_load - 32'(cyc - m_t0);
    return m_held;
  endfunction

  function automatic logic [15:0] exp_q(input logic [2:0] a);
    case (a)
      3'd0:    return {14'b0, m_run, m_to};
      3'd1:    return {14'b0, m_cont, m_run};
      3'd2:    return m_period[15:0];
      3'd3:    return m_period[31:16];
      3'd4:    return m_snap[15:0];
      3'd5:    return m_snap[31:16];
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge Clock) begin : model
    logic [31:0] cnt;
    logic        wr, term, cont_new;
    longint      eff;
    cyc <= cyc + 1;
    if (!Resetn) begin
      m_run <= 1'b0; m_to <= 1'b0; m_cont <= 1'b0;
      m_period <= PRST; m_snap <= 32'd0; m_held <= 32'd0;
    end else begin
      cnt  = m_count();
      wr   = cs & W;
      eff  = (m_load == 32'd0) ? 64'sd1 : longint'(m_load);
      // Timeout lands on the P-th edge after the load edge.
      term = m_run && ((cyc - m_t0 + 1) >= eff);
      cont_new = (wr && A == 3'd1) ? D[1] : m_cont;
      m_cont <= cont_new;
      if (term) m_to <= 1'b1;
      else if (wr && A == 3'd0) m_to <= 1'b0;
      if (wr && A == 3'd2) m_period[15:0] <= D;
      if (wr && A == 3'd3) m_period[31:16] <= D;
      if (wr && A == 3'd4) m_snap <= cnt;
      if (wr && A == 3'd1 && D[2]) begin
        m_run <= 1'b0; m_held <= cnt;
      end else if (wr && A == 3'd1 && D[0]) begin
        m_run <= 1'b1; m_load <= m_period; m_t0 <= cyc + 1;
      end else if (term) begin
        if (cont_new) begin
          m_load <= m_period; m_t0 <= cyc + 1;
        end else begin
          m_run <= 1'b0; m_held <= 32'd0;
        end
      end
    end
  end

  always @(negedge Clock) begin
    if (chk_en) begin
      n_chk = n_chk + 1;
      if (Q !== exp_q(A)) begin
        n_fail = n_fail + 1;
        $display("FAIL q_track cyc=%0d A=%0d actual %h required %h", cyc, A, Q, exp_q(A));
      end
      n_chk = n_chk + 1;
      if (TO !== m_to) begin
        n_fail = n_fail + 1;
        $display("FAIL to_track cyc=%0d actual %b required %b", cyc, TO, m_to);
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge Clock); #1;
      cs = 1'b0; W = 1'b0;
      rot = (rot == 3'd7) ? 3'd0 : rot + 3'd1;
      A = rot;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    cs = 1'b1; W = 1'b1; A = a; D = d;
    tick(1);
  endtask

  task automatic rd(input string name, input logic [2:0] a, input logic [15:0] exp);
    A = a;
    #1;
    chk(name, Q, exp);
  endtask

  initial begin
    // 1: reset state
    Resetn = 1'b0;
    @(posedge Clock); @(posedge Clock); #1;
    Resetn = 1'b1;
    chk_en = 1'b1;
    rd("rst_status", 3'd0, 16'h0000);
    rd("rst_ctrl",   3'd1, 16'h0000);
    rd("rst_perlo",  3'd2, 16'hF080);
    rd("rst_perhi",  3'd3, 16'h02FA);
    rd("rst_snaplo", 3'd4, 16'h0000);
    rd("rst_snaphi", 3'd5, 16'h0000);
    rd("rst_off6",   3'd6, 16'h0000);
    chk("rst_to", {15'b0, TO}, 16'h0000);

    // 2: one-shot, P=5
    wr(3'd2, 16'd5);
    wr(3'd3, 16'd0);
    wr(3'd1, 16'h0001);
    tick(4);
    chk("oneshot_to_c4", {15'b0, TO}, 16'h0000);
    tick(1);
    chk("oneshot_to_c5", {15'b0, TO}, 16'h0001);
    rd("oneshot_status", 3'd0, 16'h0001);
    wr(3'd4, 16'h0000);
    rd("oneshot_count", 3'd4, 16'h0000);
    tick(3);
    rd("to_sticky", 3'd0, 16'h0001);

    // 3: continuous, P=5, clear in cycle 7
    wr(3'd0, 16'h0000);
    wr(3'd1, 16'h0003);
    tick(5);
    chk("cont_to_c5", {15'b0, TO}, 16'h0001);
    tick(2);
    wr(3'd0, 16'h0000);
    chk("cont_to_c8", {15'b0, TO}, 16'h0000);
    tick(1);
    chk("cont_to_c9", {15'b0, TO}, 16'h0000);
    tick(1);
    chk("cont_to_c10", {15'b0, TO}, 16'h0001);
    rd("cont_status", 3'd0, 16'h0003);

    // 4: snapshot while running, then stop and freeze
    wr(3'd1, 16'h0004);
    wr(3'd2, 16'd100);
    wr(3'd0, 16'h0000);
    wr(3'd1, 16'h0001);
    tick(10);
    wr(3'd4, 16'h0000);
    rd("snap_lo_90", 3'd4, 16'd90);
    rd("snap_hi_0",  3'd5, 16'h0000);
    wr(3'd1, 16'h0004);
    rd("stop_ctrl", 3'd1, 16'h0000);
    tick(5);
    wr(3'd4, 16'h0000);
    rd("snap_frozen", 3'd4, 16'd89);

    // 5: clear on terminal edge, START+STOP, period 0
    wr(3'd2, 16'd3);
    wr(3'd0, 16'h0000);
    wr(3'd1, 16'h0003);
    tick(3);
    chk("p3_to_c3", {15'b0, TO}, 16'h0001);
    wr(3'd0, 16'h0000);
    chk("p3_cleared", {15'b0, TO}, 16'h0000);
    tick(1);
    wr(3'd0, 16'h0000);
    chk("set_beats_clear", {15'b0, TO}, 16'h0001);
    wr(3'd1, 16'h0004);
    wr(3'd0, 16'h0000);
    wr(3'd1, 16'h0005);
    rd("start_stop_ctrl", 3'd1, 16'h0000);
    tick(8);
    chk("start_stop_to", {15'b0, TO}, 16'h0000);
    wr(3'd2, 16'd0);
    wr(3'd1, 16'h0001);
    chk("p0_to_c0", {15'b0, TO}, 16'h0000);
    tick(1);
    chk("p0_to_c1", {15'b0, TO}, 16'h0001);
    rd("p0_status", 3'd0, 16'h0001);

    // 6: reset mid-count, with a START write presented during reset
    wr(3'd0, 16'h0000);
    wr(3'd2, 16'd1000);
    wr(3'd1, 16'h0001);
    tick(20);
    Resetn = 1'b0; cs = 1'b1; W = 1'b1; A = 3'd1; D = 16'h0001;
    @(posedge Clock); #1;
    Resetn = 1'b1; cs = 1'b0; W = 1'b0;
    chk("mid_rst_to", {15'b0, TO}, 16'h0000);
    rd("mid_rst_status", 3'd0, 16'h0000);
    rd("mid_rst_ctrl",   3'd1, 16'h0000);
    rd("mid_rst_perlo",  3'd2, 16'hF080);
    rd("mid_rst_perhi",  3'd3, 16'h02FA);
    tick(1200);
    chk("post_rst_no_to", {15'b0, TO}, 16'h0000);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
